axis_stream_tap: RTL

//  Passive, parametrised tap on one AXI-Stream link (e.g. CORDIC output -> consumer). Samples every

---
 rtl/axis_tap_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 59 +++++
 rtl/axis_stream_tap.sv | 124 ++++++++++++
 3 files changed

// File: rtl/axis_tap_pkg.sv
// Shared types, default geometry and field helper for the AXI-Stream tap.
package axis_tap_pkg;

    localparam int unsigned TAP_DATA_WIDTH  = 32;
    localparam int unsigned TAP_FIELD_LSB   = 16;
    localparam int unsigned TAP_FIELD_WIDTH = 16;
    localparam int unsigned TAP_OUT_WIDTH   = 32;
    localparam int unsigned TAP_SIGN_EXTEND = 1;
    localparam int unsigned TAP_FIFO_DEPTH  = 16;
    localparam int unsigned TAP_DECIM_WIDTH = 16;
    localparam int unsigned TAP_CNT_WIDTH   = 16;

    typedef struct packed {
        logic                     last;
        logic [TAP_OUT_WIDTH-1:0] data;
    } tap_entry_t;

    // Pull the field out of an observed beat and widen it to the monitor width.
    function automatic logic [TAP_OUT_WIDTH-1:0] tap_extract(input logic [TAP_DATA_WIDTH-1:0] tdata);
        logic [TAP_FIELD_WIDTH-1:0] field;
        logic                       fill;
        logic [TAP_OUT_WIDTH-1:0]   ext;
        field = tdata[TAP_FIELD_LSB +: TAP_FIELD_WIDTH];
        fill  = (TAP_SIGN_EXTEND != 0) ? field[TAP_FIELD_WIDTH-1] : 1'b0;
        ext   = {TAP_OUT_WIDTH{fill}};
        ext[TAP_FIELD_WIDTH-1:0] = field;
        return ext;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with synchronous active-high reset.
module sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // Full/empty come from the registered count, so a same-cycle pop never makes room for a push.
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/axis_stream_tap.sv
// Passive AXI-Stream tap: decimates handshaked beats, buffers a bit field and replays it on a monitor master.
module axis_stream_tap
    import axis_tap_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = TAP_DATA_WIDTH,
    parameter int unsigned FIELD_LSB   = TAP_FIELD_LSB,
    parameter int unsigned FIELD_WIDTH = TAP_FIELD_WIDTH,
    parameter int unsigned OUT_WIDTH   = TAP_OUT_WIDTH,
    parameter int unsigned SIGN_EXTEND = TAP_SIGN_EXTEND,
    parameter int unsigned FIFO_DEPTH  = TAP_FIFO_DEPTH,
    parameter int unsigned DECIM_WIDTH = TAP_DECIM_WIDTH,
    parameter int unsigned CNT_WIDTH   = TAP_CNT_WIDTH
) (
    input  logic                   s00_axis_aclk,
    input  logic                   s00_axis_areset,
    input  logic                   tap_tvalid,
    input  logic                   tap_tready,
    input  logic                   tap_tlast,
    input  logic [DATA_WIDTH-1:0]  tap_tdata,
    input  logic                   cfg_enable,
    input  logic [DECIM_WIDTH-1:0] cfg_decim,
    input  logic                   cfg_frame_align,
    input  logic                   clr_stats,
    input  logic                   m01_axis_tready,
    output logic                   m01_axis_tvalid,
    output logic                   m01_axis_tlast,
    output logic [OUT_WIDTH-1:0]   m01_axis_tdata,
    output logic [OUT_WIDTH/8-1:0] m01_axis_tstrb,
    output logic [CNT_WIDTH-1:0]   drop_count,
    output logic                   overflow_sticky
);

    localparam int unsigned ENTRY_W = OUT_WIDTH + 1;

    logic                   obs;
    logic [DECIM_WIDTH-1:0] ratio;
    logic [DECIM_WIDTH-1:0] phase;
    logic [DECIM_WIDTH-1:0] phase_eff;
    logic [DECIM_WIDTH-1:0] phase_nxt;
    logic                   selected;
    logic                   drop;
    logic [FIELD_WIDTH-1:0] field;
    logic                   fill;
    logic [OUT_WIDTH-1:0]   field_ext;
    logic [ENTRY_W-1:0]     push_entry;
    logic [ENTRY_W-1:0]     head_entry;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   unused_tdata;

    assign obs = tap_tvalid && tap_tready && cfg_enable;

    // A phase left beyond a freshly shrunk ratio restarts at zero.
    always_comb begin
        ratio     = (cfg_decim == '0) ? DECIM_WIDTH'(1) : cfg_decim;
        phase_eff = (phase >= ratio) ? '0 : phase;
        selected  = obs && (phase_eff == '0);
        if (cfg_frame_align && tap_tlast) begin
            phase_nxt = '0;
        end else if (phase_eff == ratio - DECIM_WIDTH'(1)) begin
            phase_nxt = '0;
        end else begin
            phase_nxt = phase_eff + DECIM_WIDTH'(1);
        end
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            phase <= '0;
        end else if (obs) begin
            phase <= phase_nxt;
        end
    end

    always_comb begin
        field     = tap_tdata[FIELD_LSB +: FIELD_WIDTH];
        fill      = (SIGN_EXTEND != 0) ? field[FIELD_WIDTH-1] : 1'b0;
        field_ext = {OUT_WIDTH{fill}};
        field_ext[FIELD_WIDTH-1:0] = field;
    end

    assign unused_tdata = ^tap_tdata;
    assign push_entry   = {tap_tlast, field_ext};
    assign drop         = selected && fifo_full;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (s00_axis_aclk),
        .rst       (s00_axis_areset),
        .push      (selected),
        .push_data (push_entry),
        .pop       (m01_axis_tready),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Head is held by the FIFO until popped; idle output reads as zero.
    assign m01_axis_tvalid = !fifo_empty;
    assign m01_axis_tlast  = fifo_empty ? 1'b0 : head_entry[ENTRY_W-1];
    assign m01_axis_tdata  = fifo_empty ? '0 : head_entry[OUT_WIDTH-1:0];
    assign m01_axis_tstrb  = '1;

    // A drop in the same cycle as a clear wins: counter restarts at one.
    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            drop_count      <= '0;
            overflow_sticky <= 1'b0;
        end else if (drop) begin
            overflow_sticky <= 1'b1;
            if (clr_stats) begin
                drop_count <= CNT_WIDTH'(1);
            end else if (drop_count != '1) begin
                drop_count <= drop_count + CNT_WIDTH'(1);
            end
        end else if (clr_stats) begin
            drop_count      <= '0;
            overflow_sticky <= 1'b0;
        end
    end

endmodule
